// File: rtl/cpu_pkg.sv
// Shared CPU definitions: word width, PC step, NOP encoding, fetch state and
// fetch buffer entry layout.
package cpu_pkg;

  localparam int unsigned       WORD_W    = 32;
  localparam logic [WORD_W-1:0] PC_STEP   = 32'd4;
  localparam logic [WORD_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic {
    FS_RUN  = 1'b0,
    FS_KILL = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] addr);
    return {addr[WORD_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Instruction buffer: DEPTH-entry FIFO of {pc, instr} with push/pop/flush.
// Push into a full buffer is accepted only when a pop frees a slot that cycle.
module fetch_buffer
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  fetch_entry_t           push_entry_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  output fetch_entry_t           head_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int unsigned      PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);

  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    full_o   = (count_q == FULL_CNT);
    empty_o  = (count_q == '0);
    do_pop   = pop_i && !empty_o;
    do_push  = push_i && (!full_o || do_pop);
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_entry_i;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC ownership, imem req/ack, buffered IR output and
// redirect flush. Define FETCH_BYPASS_EN for zero-latency forwarding into an empty buffer.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] ir_o,
  output logic [31:0] pc_o,
  output logic        ir_valid_o,
  input  logic        ir_ready_i
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  fetch_state_e      state_q, state_d;
  logic [WORD_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [WORD_W-1:0] pending_pc_q, pending_pc_d;
  logic [WORD_W-1:0] redirect_pc;

  fetch_entry_t      push_entry, head;
  logic              buf_push, buf_pop, buf_flush;
  logic              buf_full, buf_empty;
  logic [CNT_W-1:0]  buf_count;
  logic              pop, ack_v, bypass;

  fetch_buffer #(
    .DEPTH (DEPTH)
  ) u_buf (
    .clk          (clk),
    .rst          (rst),
    .push_i       (buf_push),
    .push_entry_i (push_entry),
    .pop_i        (buf_pop),
    .flush_i      (buf_flush),
    .head_o       (head),
    .count_o      (buf_count),
    .full_o       (buf_full),
    .empty_o      (buf_empty)
  );

  always_comb begin
    redirect_pc = word_align(redirect_pc_i);
    push_entry  = '{pc: fetch_pc_q, instr: imem_data_i};

`ifdef FETCH_BYPASS_EN
    // Raw ack is safe here: an empty buffer in RUN always has a request up.
    bypass = !rst && (state_q == FS_RUN) && buf_empty && !redirect_i && imem_ack_i;
    if (bypass) begin
      ir_o       = imem_data_i;
      pc_o       = fetch_pc_q;
      ir_valid_o = 1'b1;
    end else begin
      ir_o       = head.instr;
      pc_o       = head.pc;
      ir_valid_o = (state_q == FS_RUN) && (buf_count != '0);
    end
`else
    bypass     = 1'b0;
    ir_o       = head.instr;
    pc_o       = head.pc;
    ir_valid_o = (state_q == FS_RUN) && (buf_count != '0);
`endif

    pop         = ir_valid_o && ir_ready_i;
    buf_pop     = pop && !bypass;
    imem_addr_o = fetch_pc_q;
    imem_req_o  = !rst && ((state_q == FS_KILL) || !buf_full || pop);
    ack_v       = imem_ack_i && imem_req_o;

    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    pending_pc_d = pending_pc_q;
    buf_flush    = redirect_i;
    buf_push     = 1'b0;

    case (state_q)
      FS_RUN: begin
        if (redirect_i) begin
          // An unanswered request must complete at its old address; its data is wrong-path.
          if (imem_req_o && !ack_v) begin
            state_d      = FS_KILL;
            pending_pc_d = redirect_pc;
          end else begin
            fetch_pc_d = redirect_pc;
          end
        end else if (ack_v) begin
          buf_push   = !(bypass && ir_ready_i);
          fetch_pc_d = fetch_pc_q + PC_STEP;
        end
      end
      FS_KILL: begin
        if (redirect_i) begin
          pending_pc_d = redirect_pc;
        end
        if (ack_v) begin
          state_d    = FS_RUN;
          fetch_pc_d = redirect_i ? redirect_pc : pending_pc_q;
        end
      end
      default: state_d = FS_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= FS_RUN;
      fetch_pc_q   <= RESET_PC;
      pending_pc_q <= RESET_PC;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      pending_pc_q <= pending_pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit (default build) with a latency-configurable
// instruction memory and a program-order scoreboard for randomized traffic.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_data_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] ir_o;
  logic [31:0] pc_o;
  logic        ir_valid_o;
  logic        ir_ready_i;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic        prev_req, prev_ack;
  logic [31:0] prev_addr;
  int unsigned wcnt, lat;
  bit          lat_rand;

  fetch_unit #(
    .RESET_PC (RST_PC),
    .DEPTH    (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_ack_i    (imem_ack_i),
    .imem_data_i   (imem_data_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .ir_o          (ir_o),
    .pc_o          (pc_o),
    .ir_valid_o    (ir_valid_o),
    .ir_ready_i    (ir_ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0000) return 32'h0401_0001;
    if (a == 32'h0000_0004) return 32'h00EC_9800;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // One clock cycle: drive at negedge, memory answers after `lat` wait cycles.
  task automatic cyc(input logic rdy, input logic redir, input logic [31:0] rpc);
    @(negedge clk);
    if (prev_req && !prev_ack) begin
      wcnt++;
    end else begin
      wcnt = 0;
      if (lat_rand) lat = $urandom_range(0, 3);
    end
    ir_ready_i    = rdy;
    redirect_i    = redir;
    redirect_pc_i = rpc;
    #1;
    imem_ack_i  = imem_req_o && (wcnt >= lat);
    imem_data_i = imem_ack_i ? mem_word(imem_addr_o) : 32'hDEAD_BEEF;
    #1;
    prev_req  = imem_req_o;
    prev_ack  = imem_ack_i;
    prev_addr = imem_addr_o;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    ir_ready_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    imem_ack_i = 1'b0; imem_data_i = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    prev_req = 1'b0; prev_ack = 1'b0; prev_addr = '0; wcnt = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ir_ready_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    imem_ack_i = 1'b0; imem_data_i = '0;
    lat = 0; lat_rand = 0;
    @(posedge clk); #1;
    n_checks++; if (imem_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_req got=%b exp=0", imem_req_o); end
    n_checks++; if (imem_addr_o !== RST_PC) begin n_fail++; $display("FAIL reset_addr got=%h exp=%h", imem_addr_o, RST_PC); end
    n_checks++; if (ir_o !== 32'h0) begin n_fail++; $display("FAIL reset_ir got=%h exp=0", ir_o); end
    n_checks++; if (pc_o !== 32'h0) begin n_fail++; $display("FAIL reset_pc got=%h exp=0", pc_o); end
    n_checks++; if (ir_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", ir_valid_o); end
    rst = 1'b0;
    prev_req = 1'b0; prev_ack = 1'b0; prev_addr = '0; wcnt = 0;
    #1;
    n_checks++; if (imem_req_o !== 1'b1) begin n_fail++; $display("FAIL release_req got=%b exp=1", imem_req_o); end
  endtask

  task automatic test_stream();
    do_reset(); lat = 0;
    for (int k = 0; k < 6; k++) begin
      cyc(1'b1, 1'b0, '0);
      n_checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'(4 * k)) begin
        n_fail++; $display("FAIL stream_req[%0d] got=%b/%h exp=1/%h", k, imem_req_o, imem_addr_o, 32'(4 * k)); end
      if (k >= 1) begin
        n_checks++; if (ir_valid_o !== 1'b1 || pc_o !== 32'(4 * (k - 1)) || ir_o !== mem_word(32'(4 * (k - 1)))) begin
          n_fail++; $display("FAIL stream_out[%0d] got=%b/%h/%h exp=1/%h/%h", k, ir_valid_o, pc_o, ir_o,
                             32'(4 * (k - 1)), mem_word(32'(4 * (k - 1)))); end
      end
      if (k == 2) begin
        n_checks++; if (ir_o !== 32'h00EC_9800) begin n_fail++; $display("FAIL stream_add got=%h exp=00ec9800", ir_o); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_pc;
    int unsigned pops;
    do_reset(); lat = 0;
    cyc(1'b0, 1'b0, '0);
    cyc(1'b0, 1'b0, '0);
    n_checks++; if (ir_valid_o !== 1'b1 || ir_o !== 32'h0401_0001) begin
      n_fail++; $display("FAIL bp_first got=%b/%h exp=1/04010001", ir_valid_o, ir_o); end
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b0, '0);
      n_checks++; if (imem_req_o !== 1'b0) begin n_fail++; $display("FAIL bp_req_drop[%0d] got=%b exp=0", k, imem_req_o); end
      n_checks++; if (ir_valid_o !== 1'b1 || ir_o !== 32'h0401_0001 || pc_o !== 32'h0) begin
        n_fail++; $display("FAIL bp_hold[%0d] got=%b/%h/%h exp=1/0/04010001", k, ir_valid_o, pc_o, ir_o); end
    end
    exp_pc = 32'h0; pops = 0;
    for (int k = 0; k < 8; k++) begin
      cyc(1'b1, 1'b0, '0);
      if (ir_valid_o) begin
        n_checks++; if (pc_o !== exp_pc || ir_o !== mem_word(exp_pc)) begin
          n_fail++; $display("FAIL bp_drain got=%h/%h exp=%h/%h", pc_o, ir_o, exp_pc, mem_word(exp_pc)); end
        exp_pc += 4; pops++;
      end
    end
    n_checks++; if (pops != 8) begin n_fail++; $display("FAIL bp_drain_count got=%0d exp=8", pops); end
  endtask

  task automatic test_kill();
    bit seen;
    do_reset(); lat = 2;
    cyc(1'b1, 1'b0, '0);
    cyc(1'b1, 1'b1, 32'h0000_002C);
    cyc(1'b1, 1'b0, '0);
    n_checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0 || imem_ack_i !== 1'b1 || ir_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL kill_hold got=%b/%h/%b/%b exp=1/0/1/0", imem_req_o, imem_addr_o, imem_ack_i, ir_valid_o); end
    cyc(1'b1, 1'b0, '0);
    n_checks++; if (imem_addr_o !== 32'h2C || ir_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL kill_addr got=%h/%b exp=2c/0", imem_addr_o, ir_valid_o); end
    seen = 0;
    for (int k = 0; k < 8 && !seen; k++) begin
      cyc(1'b1, 1'b0, '0);
      if (ir_valid_o) begin
        seen = 1;
        n_checks++; if (pc_o !== 32'h2C || ir_o !== mem_word(32'h2C)) begin
          n_fail++; $display("FAIL kill_first got=%h/%h exp=2c/%h", pc_o, ir_o, mem_word(32'h2C)); end
      end
    end
    if (!seen) begin n_checks++; n_fail++; $display("FAIL kill_timeout got=none exp=valid"); end
  endtask

  task automatic test_redirect_flush();
    do_reset(); lat = 0;
    cyc(1'b0, 1'b0, '0);
    cyc(1'b0, 1'b0, '0);
    cyc(1'b1, 1'b1, 32'h0000_002C);
    n_checks++; if (ir_valid_o !== 1'b1 || imem_ack_i !== 1'b1 || imem_addr_o !== 32'h8) begin
      n_fail++; $display("FAIL flush_pre got=%b/%b/%h exp=1/1/8", ir_valid_o, imem_ack_i, imem_addr_o); end
    cyc(1'b1, 1'b0, '0);
    n_checks++; if (ir_valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h2C) begin
      n_fail++; $display("FAIL flush_next got=%b/%b/%h exp=0/1/2c", ir_valid_o, imem_req_o, imem_addr_o); end
    cyc(1'b1, 1'b0, '0);
    n_checks++; if (ir_valid_o !== 1'b1 || pc_o !== 32'h2C || ir_o !== mem_word(32'h2C)) begin
      n_fail++; $display("FAIL flush_first got=%b/%h/%h exp=1/2c/%h", ir_valid_o, pc_o, ir_o, mem_word(32'h2C)); end
  endtask

  task automatic test_wrap();
    do_reset(); lat = 0;
    cyc(1'b1, 1'b1, 32'hFFFF_FFFF);
    cyc(1'b1, 1'b0, '0);
    n_checks++; if (imem_addr_o !== 32'hFFFF_FFFC || ir_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL wrap_top got=%h/%b exp=fffffffc/0", imem_addr_o, ir_valid_o); end
    cyc(1'b1, 1'b0, '0);
    n_checks++; if (imem_addr_o !== 32'h0) begin n_fail++; $display("FAIL wrap_addr got=%h exp=0", imem_addr_o); end
    n_checks++; if (ir_valid_o !== 1'b1 || pc_o !== 32'hFFFF_FFFC || ir_o !== mem_word(32'hFFFF_FFFC)) begin
      n_fail++; $display("FAIL wrap_out got=%b/%h/%h exp=1/fffffffc/%h", ir_valid_o, pc_o, ir_o, mem_word(32'hFFFF_FFFC)); end
    cyc(1'b1, 1'b0, '0);
    n_checks++; if (pc_o !== 32'h0 || ir_o !== 32'h0401_0001) begin
      n_fail++; $display("FAIL wrap_next got=%h/%h exp=0/04010001", pc_o, ir_o); end
  endtask

  task automatic test_reset_mid();
    do_reset(); lat = 1;
    cyc(1'b1, 1'b0, '0);
    cyc(1'b1, 1'b0, '0);
    cyc(1'b0, 1'b0, '0);
    n_checks++; if (ir_valid_o !== 1'b1 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h4) begin
      n_fail++; $display("FAIL rmid_pre got=%b/%b/%h exp=1/1/4", ir_valid_o, imem_req_o, imem_addr_o); end
    rst = 1'b1; imem_ack_i = 1'b1; imem_data_i = 32'hBAD0_BAD0;
    #1;
    n_checks++; if (imem_req_o !== 1'b0 || imem_addr_o !== RST_PC || ir_o !== 32'h0 || pc_o !== 32'h0 || ir_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL rmid_async got=%b/%h/%h/%h/%b exp=0/%h/0/0/0", imem_req_o, imem_addr_o, ir_o, pc_o, ir_valid_o, RST_PC); end
    @(posedge clk); #1;
    rst = 1'b0; imem_ack_i = 1'b0;
    prev_req = 1'b0; prev_ack = 1'b0; wcnt = 0; lat = 0;
    cyc(1'b1, 1'b0, '0);
    n_checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== RST_PC || ir_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL rmid_restart got=%b/%h/%b exp=1/%h/0", imem_req_o, imem_addr_o, ir_valid_o, RST_PC); end
    cyc(1'b1, 1'b0, '0);
    n_checks++; if (ir_valid_o !== 1'b1 || pc_o !== RST_PC || ir_o !== mem_word(RST_PC)) begin
      n_fail++; $display("FAIL rmid_first got=%b/%h/%h exp=1/%h/%h", ir_valid_o, pc_o, ir_o, RST_PC, mem_word(RST_PC)); end
  endtask

  // Scoreboard: delivered words follow program order from the last redirect target.
  task automatic test_random();
    logic [31:0] exp_pc, rpc, s_addr;
    logic        rdy, redir, s_req, s_ack, prev_redir;
    int unsigned pops;
    do_reset(); lat_rand = 1;
    exp_pc = RST_PC; prev_redir = 1'b0; pops = 0;
    for (int i = 0; i < 800; i++) begin
      rdy   = ($urandom_range(0, 3) != 0);
      redir = ($urandom_range(0, 15) == 0);
      rpc   = $urandom;
      rpc   = ($urandom_range(0, 7) == 0) ? (rpc | 32'hFFFF_FF00) : (rpc & 32'h0000_03FF);
      s_req = prev_req; s_ack = prev_ack; s_addr = prev_addr;
      cyc(rdy, redir, rpc);
      if (s_req && !s_ack) begin
        n_checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== s_addr) begin
          n_fail++; $display("FAIL rnd_req_stable[%0d] got=%b/%h exp=1/%h", i, imem_req_o, imem_addr_o, s_addr); end
      end
      n_checks++; if (imem_addr_o[1:0] !== 2'b00) begin
        n_fail++; $display("FAIL rnd_addr_align[%0d] got=%h exp=aligned", i, imem_addr_o); end
      if (prev_redir) begin
        n_checks++; if (ir_valid_o !== 1'b0) begin
          n_fail++; $display("FAIL rnd_valid_after_redirect[%0d] got=%b exp=0", i, ir_valid_o); end
      end
      if (ir_valid_o && rdy && !redir) begin
        n_checks++; if (pc_o !== exp_pc || ir_o !== mem_word(exp_pc)) begin
          n_fail++; $display("FAIL rnd_pop[%0d] got=%h/%h exp=%h/%h", i, pc_o, ir_o, exp_pc, mem_word(exp_pc)); end
        exp_pc += 4; pops++;
      end
      if (redir) exp_pc = rpc & 32'hFFFF_FFFC;
      prev_redir = redir;
    end
    n_checks++; if (pops < 50) begin n_fail++; $display("FAIL rnd_progress got=%0d exp>=50", pops); end
    lat_rand = 0; lat = 0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_kill();
    test_redirect_flush();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage feeding the control unit and the register-read stage. Owns the program counter, issues word reads to instruction memory over a req/ack handshake, and buffers returned words with their PC in a small FIFO. Presents `ir_o` with a valid/ready handshake and accepts PC redirects from branch/jump resolution, discarding all wrong-path words.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC fetched first after reset.
- `DEPTH`, default 2: instruction buffer entries, power of two, ≥2.
- `clk` input 1: clock; all state on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `imem_req_o` output 1: read request to instruction memory.
- `imem_addr_o` output 32: byte address of requested word (bits [1:0] always 0).
- `imem_ack_i` input 1: request accepted; `imem_data_i` valid this cycle.
- `imem_data_i` input 32: returned instruction word.
- `redirect_i` input 1: branch taken / jump / jr; flush and refetch.
- `redirect_pc_i` input 32: new PC; bits [1:0] ignored (forced 0).
- `ir_o` output 32: instruction to control unit / decode.
- `pc_o` output 32: PC of `ir_o`.
- `ir_valid_o` output 1: `ir_o`/`pc_o` valid.
- `ir_ready_i` input 1: downstream accepts; pop when `ir_valid_o && ir_ready_i`.

## Operation
- States: RUN, KILL. Reset → RUN.
- `fetch_pc` register: address of next word to request.
- RUN: `imem_req_o = (count < DEPTH) || pop`; `imem_addr_o = fetch_pc`. On ack: push {fetch_pc, imem_data_i}, `fetch_pc += 4` (wraps 32'hFFFF_FFFC → 0).
- Once asserted, `imem_req_o` and `imem_addr_o` stay stable until ack (memory contract).
- Redirect in RUN: buffer flushed (count = 0), same-cycle ack data dropped, same-cycle pop ignored downstream-side (word is wrong-path). If `imem_req_o && !imem_ack_i`: → KILL, latch target in `pending_pc`. Else `fetch_pc = redirect_pc_i`, stay RUN.
- KILL: `imem_req_o = 1` at old address; `ir_valid_o = 0`; on ack data dropped, `fetch_pc = pending_pc`, → RUN. Further redirect in KILL overwrites `pending_pc`; redirect coincident with the ack uses `redirect_pc_i`.
- Push and pop in the same cycle with count == DEPTH allowed (pop frees slot).
- Buffer outputs are head entry; `ir_o` holds value while `ir_valid_o && !ir_ready_i`.

## Timing
- Reset values: `imem_req_o`=0 during reset, `imem_addr_o`=RESET_PC, `ir_o`=0, `pc_o`=0, `ir_valid_o`=0, count=0, state RUN.
- First `imem_req_o` in first cycle after `rst` deasserts.
- Latency (macro off): ack in cycle t → `ir_valid_o` at t+1.
- Throughput: one instruction/cycle with zero-wait memory and `ir_ready_i` held 1.
- Redirect in cycle t (no outstanding request) → `imem_addr_o = redirect_pc_i` at t+1, `ir_valid_o` = 0 at t+1.
- Reset mid-operation: all state cleared immediately; in-flight ack ignored.

## Configuration
- `FETCH_BYPASS_EN` defined: when buffer empty, state RUN, no redirect, and ack arrives, `ir_o`/`pc_o` driven combinationally from `imem_data_i`/`fetch_pc`, `ir_valid_o`=1 same cycle; word pushed only if `!ir_ready_i`. Latency 0 cycles.
- Undefined: all output from buffer registers; latency 1 cycle; no combinational path from `imem_*` to `ir_*`.

## Structure
- Shared package `cpu_pkg`: `WORD_W`=32, `PC_STEP`=4, `NOP_INSTR`=32'h0, fetch state enum {FS_RUN, FS_KILL}.
- One sub-module `fetch_buffer` (parameterised DEPTH FIFO of 64-bit {pc, instr}, push/pop/flush, count, full/empty).

## Test plan
- Reset release, zero-wait memory returning 32'h0401_0001 (addi) at 0x0, 32'h00EC_9800 (add) at 0x4, ready=1 → `ir_o` sequence matches, `pc_o` 0x0, 0x4; one per cycle.
- Ready held 0 after first word → buffer fills to DEPTH, `imem_req_o` drops, `ir_o` stable; ready=1 → words drain in order, no loss/duplication.
- Memory with 3-cycle ack; redirect to 0x2C on second wait cycle → old ack data dropped (KILL), next `imem_addr_o`=0x2C, first valid `pc_o`=0x2C.
- Redirect with 2 buffered words and simultaneous ack → all three discarded, next request 0x2C, `ir_valid_o`=0 next cycle.
- `fetch_pc` at 0xFFFF_FFFC → next request 0x0000_0000.
- `rst` pulsed mid-stream with request outstanding → outputs return to reset values asynchronously; fetch restarts at RESET_PC; with `FETCH_BYPASS_EN`, first `ir_valid_o` in ack cycle.
